// File: rtl/dll_tx_replay_ctrl.sv
// Transmit DLL sequence/replay controller: owns NEXT_TRANSMIT_SEQ, ACKD_SEQ, outstanding count, replay timer and REPLAY_NUM.
// Latency: issue -> next_seq_o/outstanding_o 1 cycle; ACK/NAK -> purge/dllp_err 1 cycle; replay pending -> replay_req_o >= 1 cycle.
// Backpressure: seq_full_o tells the packetizer to stall; replay_req_o is held off while replay_busy_i. Optional stats: DLL_REPLAY_STATS_EN.
module dll_tx_replay_ctrl #(
  parameter int SEQ_BITS           = 12,
  parameter int MAX_TLP_PER_CYCLE  = 2,
  parameter int REPLAY_TIMER_LIMIT = 711,
  parameter int REPLAY_NUM_MAX     = 3,
  parameter int TIMER_BITS         = 16,
  localparam int IW                = $clog2(MAX_TLP_PER_CYCLE + 1),
  localparam int RN_BITS           = (REPLAY_NUM_MAX < 1) ? 1 : $clog2(REPLAY_NUM_MAX + 1)
) (
  input  logic                sclk,
  input  logic                srst_n,
  input  logic                dl_up_i,
  input  logic [IW-1:0]       tlp_issue_cnt_i,
  output logic [SEQ_BITS-1:0] next_seq_o,
  output logic [SEQ_BITS-1:0] ackd_seq_o,
  output logic [SEQ_BITS-1:0] outstanding_o,
  output logic                seq_full_o,
  input  logic                acknak_valid_i,
  input  logic                acknak_nak_i,
  input  logic [SEQ_BITS-1:0] acknak_seq_i,
  output logic                purge_valid_o,
  output logic [SEQ_BITS-1:0] purge_cnt_o,
  output logic                replay_req_o,
  input  logic                replay_busy_i,
  output logic                replay_rollover_o,
`ifdef DLL_REPLAY_STATS_EN
  output logic [15:0]         replay_cnt_o,
  output logic [15:0]         rollover_cnt_o,
`endif
  output logic                dllp_err_o
);

  logic [SEQ_BITS-1:0]   next_seq_q, next_seq_d;
  logic [SEQ_BITS-1:0]   ackd_seq_q, ackd_seq_d;
  logic [SEQ_BITS-1:0]   outstanding_q, outstanding_d;
  logic [TIMER_BITS-1:0] timer_q, timer_d;
  logic [RN_BITS-1:0]    replay_num_q, replay_num_d;
  logic                  replay_pending_q, replay_pending_d;
  logic                  purge_valid_q, purge_valid_d;
  logic [SEQ_BITS-1:0]   purge_cnt_q, purge_cnt_d;
  logic                  replay_req_q, replay_req_d;
  logic                  rollover_q, rollover_d;
  logic                  dllp_err_q, dllp_err_d;

  logic [SEQ_BITS-1:0]   ack_dist;
  logic [SEQ_BITS-1:0]   left_after_purge;
  logic [RN_BITS-1:0]    replay_num_base;
  logic                  in_range;
  logic                  progress;
  logic                  nak_replay;
  logic                  fire;
  logic                  timer_expire;

  // Next-state: sequence bookkeeping, ACK/NAK validation, replay timer and scheduling
  always_comb begin
    ack_dist         = acknak_seq_i - ackd_seq_q;
    left_after_purge = outstanding_q - ack_dist;
    // Only modular distances are compared, so wrap-around needs no special case
    in_range         = (ack_dist <= outstanding_q);
    progress         = acknak_valid_i && in_range && (ack_dist != '0);
    // A NAK that acknowledges everything still outstanding has nothing to replay
    nak_replay       = acknak_valid_i && acknak_nak_i && in_range && (left_after_purge != '0);
    fire             = replay_pending_q && !replay_busy_i;

    next_seq_d       = next_seq_q + SEQ_BITS'(tlp_issue_cnt_i);
    ackd_seq_d       = progress ? acknak_seq_i : ackd_seq_q;
    outstanding_d    = next_seq_d - SEQ_BITS'(1) - ackd_seq_d;

    timer_expire     = 1'b0;
    timer_d          = timer_q;
    if (outstanding_q == '0) begin
      timer_d = '0;
    end else if (!replay_busy_i && !replay_pending_q) begin
      timer_d      = timer_q + TIMER_BITS'(1);
      timer_expire = (timer_q == TIMER_BITS'(REPLAY_TIMER_LIMIT - 1)) && !progress;
    end
    if (progress || fire) begin
      timer_d = '0;
    end

    // Forward progress restarts the retry count before any replay issued this cycle is counted
    replay_num_base  = progress ? '0 : replay_num_q;
    replay_num_d     = replay_num_base;
    rollover_d       = 1'b0;
    if (fire) begin
      if (replay_num_base == RN_BITS'(REPLAY_NUM_MAX)) begin
        rollover_d   = 1'b1;
        replay_num_d = '0;
      end else begin
        replay_num_d = replay_num_base + RN_BITS'(1);
      end
    end

    // A NAK arriving while a replay is already pending folds into that single replay
    replay_pending_d = !fire && (replay_pending_q || nak_replay || timer_expire);

    replay_req_d     = fire;
    purge_valid_d    = progress;
    purge_cnt_d      = progress ? ack_dist : '0;
    dllp_err_d       = acknak_valid_i && !in_range;
  end

  // State registers; link down behaves exactly like reset
  always_ff @(posedge sclk) begin
    if (!srst_n || !dl_up_i) begin
      next_seq_q       <= '0;
      ackd_seq_q       <= '1;
      outstanding_q    <= '0;
      timer_q          <= '0;
      replay_num_q     <= '0;
      replay_pending_q <= 1'b0;
      purge_valid_q    <= 1'b0;
      purge_cnt_q      <= '0;
      replay_req_q     <= 1'b0;
      rollover_q       <= 1'b0;
      dllp_err_q       <= 1'b0;
    end else begin
      next_seq_q       <= next_seq_d;
      ackd_seq_q       <= ackd_seq_d;
      outstanding_q    <= outstanding_d;
      timer_q          <= timer_d;
      replay_num_q     <= replay_num_d;
      replay_pending_q <= replay_pending_d;
      purge_valid_q    <= purge_valid_d;
      purge_cnt_q      <= purge_cnt_d;
      replay_req_q     <= replay_req_d;
      rollover_q       <= rollover_d;
      dllp_err_q       <= dllp_err_d;
    end
  end

  assign next_seq_o        = next_seq_q;
  assign ackd_seq_o        = ackd_seq_q;
  assign outstanding_o     = outstanding_q;
  assign seq_full_o        = outstanding_q[SEQ_BITS-1];
  assign purge_valid_o     = purge_valid_q;
  assign purge_cnt_o       = purge_cnt_q;
  assign replay_req_o      = replay_req_q;
  assign replay_rollover_o = rollover_q;
  assign dllp_err_o        = dllp_err_q;

`ifdef DLL_REPLAY_STATS_EN
  logic [15:0] replay_cnt_q, rollover_cnt_q;

  // Saturating pulse counters; they survive link-down so history spans retrains
  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      replay_cnt_q   <= '0;
      rollover_cnt_q <= '0;
    end else begin
      if (replay_req_q && (replay_cnt_q != 16'hFFFF)) begin
        replay_cnt_q <= replay_cnt_q + 16'd1;
      end
      if (rollover_q && (rollover_cnt_q != 16'hFFFF)) begin
        rollover_cnt_q <= rollover_cnt_q + 16'd1;
      end
    end
  end

  assign replay_cnt_o   = replay_cnt_q;
  assign rollover_cnt_o = rollover_cnt_q;
`endif

`ifndef SYNTHESIS
  // Packetizer must not assign sequence numbers while the window is full
  a_no_issue_when_full : assert property (@(posedge sclk) disable iff (!srst_n || !dl_up_i)
    !(seq_full_o && (tlp_issue_cnt_i != '0)));
`endif

endmodule

// File: tb/tb_dll_tx_replay_ctrl.sv
module tb_dll_tx_replay_ctrl;

  logic        sclk = 1'b0;
  logic        srst_n;
  logic        dl_up_i;
  logic [1:0]  tlp_issue_cnt_i;
  logic [11:0] next_seq_o;
  logic [11:0] ackd_seq_o;
  logic [11:0] outstanding_o;
  logic        seq_full_o;
  logic        acknak_valid_i;
  logic        acknak_nak_i;
  logic [11:0] acknak_seq_i;
  logic        purge_valid_o;
  logic [11:0] purge_cnt_o;
  logic        replay_req_o;
  logic        replay_busy_i;
  logic        replay_rollover_o;
  logic        dllp_err_o;
`ifdef DLL_REPLAY_STATS_EN
  logic [15:0] replay_cnt_o;
  logic [15:0] rollover_cnt_o;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  dll_tx_replay_ctrl #(
    .SEQ_BITS          (12),
    .MAX_TLP_PER_CYCLE (2),
    .REPLAY_TIMER_LIMIT(20),
    .REPLAY_NUM_MAX    (3),
    .TIMER_BITS        (16)
  ) dut (
    .sclk             (sclk),
    .srst_n           (srst_n),
    .dl_up_i          (dl_up_i),
    .tlp_issue_cnt_i  (tlp_issue_cnt_i),
    .next_seq_o       (next_seq_o),
    .ackd_seq_o       (ackd_seq_o),
    .outstanding_o    (outstanding_o),
    .seq_full_o       (seq_full_o),
    .acknak_valid_i   (acknak_valid_i),
    .acknak_nak_i     (acknak_nak_i),
    .acknak_seq_i     (acknak_seq_i),
    .purge_valid_o    (purge_valid_o),
    .purge_cnt_o      (purge_cnt_o),
    .replay_req_o     (replay_req_o),
    .replay_busy_i    (replay_busy_i),
    .replay_rollover_o(replay_rollover_o),
`ifdef DLL_REPLAY_STATS_EN
    .replay_cnt_o     (replay_cnt_o),
    .rollover_cnt_o   (rollover_cnt_o),
`endif
    .dllp_err_o       (dllp_err_o)
  );

  always #5 sclk = ~sclk;

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic clear_link();
    tlp_issue_cnt_i = 2'd0;
    acknak_valid_i  = 1'b0;
    acknak_nak_i    = 1'b0;
    replay_busy_i   = 1'b0;
    dl_up_i         = 1'b0;
    step();
    dl_up_i = 1'b1;
  endtask

  task automatic send_acknak(input logic nak, input logic [11:0] seq);
    acknak_valid_i = 1'b1;
    acknak_nak_i   = nak;
    acknak_seq_i   = seq;
    step();
    acknak_valid_i = 1'b0;
    acknak_nak_i   = 1'b0;
  endtask

  task automatic test_reset();
    srst_n = 1'b0;
    step();
    step();
    srst_n = 1'b1;
    check_cnt++; if (next_seq_o !== 12'd0) $display("FAIL reset_next_seq: got %0d want 0", next_seq_o); else pass_cnt++;
    check_cnt++; if (ackd_seq_o !== 12'hFFF) $display("FAIL reset_ackd_seq: got %0d want 4095", ackd_seq_o); else pass_cnt++;
    check_cnt++; if (outstanding_o !== 12'd0) $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); else pass_cnt++;
    check_cnt++; if ({seq_full_o, purge_valid_o, replay_req_o, replay_rollover_o, dllp_err_o} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {seq_full_o, purge_valid_o, replay_req_o, replay_rollover_o, dllp_err_o}); else pass_cnt++;
  endtask

  task automatic test_issue_ack();
    clear_link();
    tlp_issue_cnt_i = 2'd2;
    repeat (3) step();
    tlp_issue_cnt_i = 2'd0;
    check_cnt++; if (next_seq_o !== 12'd6) $display("FAIL issue_next_seq: got %0d want 6", next_seq_o); else pass_cnt++;
    check_cnt++; if (outstanding_o !== 12'd6) $display("FAIL issue_outstanding: got %0d want 6", outstanding_o); else pass_cnt++;
    send_acknak(1'b0, 12'd3);
    check_cnt++; if (ackd_seq_o !== 12'd3) $display("FAIL ack_ackd_seq: got %0d want 3", ackd_seq_o); else pass_cnt++;
    check_cnt++; if (purge_valid_o !== 1'b1 || purge_cnt_o !== 12'd4)
      $display("FAIL ack_purge: got vld=%b cnt=%0d want vld=1 cnt=4", purge_valid_o, purge_cnt_o); else pass_cnt++;
    check_cnt++; if (outstanding_o !== 12'd2) $display("FAIL ack_outstanding: got %0d want 2", outstanding_o); else pass_cnt++;
    step();
    check_cnt++; if (purge_valid_o !== 1'b0) $display("FAIL ack_purge_pulse: got %b want 0", purge_valid_o); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [11:0] ns;
    clear_link();
    ns = 12'd0;
    // Issue 2 per cycle while acknowledging everything issued before this cycle
    for (int i = 0; i < 2047; i++) begin
      tlp_issue_cnt_i = 2'd2;
      acknak_valid_i  = 1'b1;
      acknak_nak_i    = 1'b0;
      acknak_seq_i    = ns - 12'd1;
      step();
      ns = ns + 12'd2;
    end
    acknak_valid_i = 1'b0;
    check_cnt++; if (next_seq_o !== 12'd4094 || ackd_seq_o !== 12'd4091)
      $display("FAIL wrap_setup: got next=%0d ackd=%0d want next=4094 ackd=4091", next_seq_o, ackd_seq_o); else pass_cnt++;
    tlp_issue_cnt_i = 2'd2;
    step();
    check_cnt++; if (next_seq_o !== 12'd0) $display("FAIL wrap_next_seq_zero: got %0d want 0", next_seq_o); else pass_cnt++;
    step();
    tlp_issue_cnt_i = 2'd0;
    check_cnt++; if (next_seq_o !== 12'd2 || outstanding_o !== 12'd6)
      $display("FAIL wrap_issue: got next=%0d out=%0d want next=2 out=6", next_seq_o, outstanding_o); else pass_cnt++;
    send_acknak(1'b0, 12'd1);
    check_cnt++; if (purge_valid_o !== 1'b1 || purge_cnt_o !== 12'd6)
      $display("FAIL wrap_purge: got vld=%b cnt=%0d want vld=1 cnt=6", purge_valid_o, purge_cnt_o); else pass_cnt++;
    check_cnt++; if (ackd_seq_o !== 12'd1 || outstanding_o !== 12'd0)
      $display("FAIL wrap_ack: got ackd=%0d out=%0d want ackd=1 out=0", ackd_seq_o, outstanding_o); else pass_cnt++;
  endtask

  task automatic test_nak();
    clear_link();
    tlp_issue_cnt_i = 2'd2;
    repeat (7) step();
    tlp_issue_cnt_i = 2'd1;
    step();
    tlp_issue_cnt_i = 2'd0;
    send_acknak(1'b0, 12'd9);
    check_cnt++; if (ackd_seq_o !== 12'd9 || outstanding_o !== 12'd5)
      $display("FAIL nak_setup: got ackd=%0d out=%0d want ackd=9 out=5", ackd_seq_o, outstanding_o); else pass_cnt++;
    step();
    send_acknak(1'b1, 12'd11);
    check_cnt++; if (purge_valid_o !== 1'b1 || purge_cnt_o !== 12'd2 || replay_req_o !== 1'b0)
      $display("FAIL nak_purge: got vld=%b cnt=%0d req=%b want vld=1 cnt=2 req=0", purge_valid_o, purge_cnt_o, replay_req_o); else pass_cnt++;
    check_cnt++; if (outstanding_o !== 12'd3) $display("FAIL nak_outstanding: got %0d want 3", outstanding_o); else pass_cnt++;
    step();
    check_cnt++; if (replay_req_o !== 1'b1 || replay_rollover_o !== 1'b0)
      $display("FAIL nak_replay_req: got req=%b roll=%b want req=1 roll=0", replay_req_o, replay_rollover_o); else pass_cnt++;
    step();
    check_cnt++; if (replay_req_o !== 1'b0) $display("FAIL nak_replay_pulse: got %b want 0", replay_req_o); else pass_cnt++;
    // NAK that acknowledges all outstanding TLPs: purge only, no replay
    send_acknak(1'b1, 12'd14);
    check_cnt++; if (purge_cnt_o !== 12'd3 || outstanding_o !== 12'd0)
      $display("FAIL nak_suppress_purge: got cnt=%0d out=%0d want cnt=3 out=0", purge_cnt_o, outstanding_o); else pass_cnt++;
    step();
    check_cnt++; if (replay_req_o !== 1'b0) $display("FAIL nak_suppress_req1: got %b want 0", replay_req_o); else pass_cnt++;
    step();
    check_cnt++; if (replay_req_o !== 1'b0) $display("FAIL nak_suppress_req2: got %b want 0", replay_req_o); else pass_cnt++;
  endtask

  task automatic test_dllp_err();
    tlp_issue_cnt_i = 2'd2;
    step();
    tlp_issue_cnt_i = 2'd0;
    send_acknak(1'b0, 12'd22);
    check_cnt++; if (dllp_err_o !== 1'b1 || purge_valid_o !== 1'b0)
      $display("FAIL err_pulse: got err=%b purge=%b want err=1 purge=0", dllp_err_o, purge_valid_o); else pass_cnt++;
    check_cnt++; if (ackd_seq_o !== 12'd14 || outstanding_o !== 12'd2)
      $display("FAIL err_state: got ackd=%0d out=%0d want ackd=14 out=2", ackd_seq_o, outstanding_o); else pass_cnt++;
    step();
    check_cnt++; if (dllp_err_o !== 1'b0) $display("FAIL err_pulse_end: got %b want 0", dllp_err_o); else pass_cnt++;
  endtask

  task automatic test_timer_replay();
    int waited;
    clear_link();
    tlp_issue_cnt_i = 2'd1;
    step();
    tlp_issue_cnt_i = 2'd0;
    // Timer limit 20: 20 counting cycles plus one cycle from pending to request
    for (int r = 0; r < 5; r++) begin
      waited = 0;
      do begin
        step();
        waited++;
      end while (replay_req_o !== 1'b1 && waited < 100);
      check_cnt++; if (waited !== 21) $display("FAIL timer_wait_%0d: got %0d cycles want 21", r, waited); else pass_cnt++;
      check_cnt++; if (replay_rollover_o !== (r == 3))
        $display("FAIL timer_rollover_%0d: got %b want %b", r, replay_rollover_o, (r == 3)); else pass_cnt++;
      replay_busy_i = 1'b1;
      repeat (10) step();
      replay_busy_i = 1'b0;
    end
  endtask

  task automatic test_full_and_linkdown();
    clear_link();
    replay_busy_i   = 1'b1;
    tlp_issue_cnt_i = 2'd2;
    repeat (1023) step();
    check_cnt++; if (outstanding_o !== 12'd2046 || seq_full_o !== 1'b0)
      $display("FAIL full_below: got out=%0d full=%b want out=2046 full=0", outstanding_o, seq_full_o); else pass_cnt++;
    step();
    tlp_issue_cnt_i = 2'd0;
    check_cnt++; if (outstanding_o !== 12'd2048 || seq_full_o !== 1'b1)
      $display("FAIL full_at: got out=%0d full=%b want out=2048 full=1", outstanding_o, seq_full_o); else pass_cnt++;
    send_acknak(1'b0, 12'd0);
    check_cnt++; if (outstanding_o !== 12'd2047 || seq_full_o !== 1'b0)
      $display("FAIL full_release: got out=%0d full=%b want out=2047 full=0", outstanding_o, seq_full_o); else pass_cnt++;
    // Duplicate-position NAK schedules a replay that is held by replay_busy_i
    send_acknak(1'b1, 12'd0);
    check_cnt++; if (replay_req_o !== 1'b0 || purge_valid_o !== 1'b0)
      $display("FAIL linkdown_pending: got req=%b purge=%b want req=0 purge=0", replay_req_o, purge_valid_o); else pass_cnt++;
    dl_up_i = 1'b0;
    step();
    check_cnt++; if (next_seq_o !== 12'd0 || ackd_seq_o !== 12'hFFF || outstanding_o !== 12'd0)
      $display("FAIL linkdown_state: got next=%0d ackd=%0d out=%0d want 0/4095/0", next_seq_o, ackd_seq_o, outstanding_o); else pass_cnt++;
    dl_up_i       = 1'b1;
    replay_busy_i = 1'b0;
    step();
    check_cnt++; if (replay_req_o !== 1'b0) $display("FAIL linkdown_no_replay1: got %b want 0", replay_req_o); else pass_cnt++;
    step();
    check_cnt++; if (replay_req_o !== 1'b0) $display("FAIL linkdown_no_replay2: got %b want 0", replay_req_o); else pass_cnt++;
  endtask

  initial begin
    srst_n          = 1'b0;
    dl_up_i         = 1'b1;
    tlp_issue_cnt_i = 2'd0;
    acknak_valid_i  = 1'b0;
    acknak_nak_i    = 1'b0;
    acknak_seq_i    = 12'd0;
    replay_busy_i   = 1'b0;
    test_reset();
    test_issue_ack();
    test_wrap();
    test_nak();
    test_dllp_err();
    test_timer_replay();
    test_full_and_linkdown();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
